// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer
//
// Purpose:
//   Instruction prefetch queue placed just before the fetch stage. It issues
//   in-order word reads to instruction memory and buffers the returned
//   {PC, instruction} pairs. Fetch reads them through a valid/ready handshake.
//   A taken branch or jump from execute (PCSrcE/PCTargetE) flushes the queue,
//   restarts fetching at the target and throws away responses that are still
//   in flight for the old path.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-low reset
//   imem_req_valid/ready/addr    read request channel to instruction memory
//   imem_rsp_valid/data          in-order read response channel
//   PCSrcE, PCTargetE            one-cycle redirect strobe and target address
//   instr_valid, instr_ready     head-of-queue handshake with fetch
//   InstrF, PCF, PCPlus4F        head instruction, its PC, and PC + 4
//
// Optional feature (macro PREFETCH_PERF_EN):
//   Adds perf_flush_cnt (counts redirects) and perf_empty_cnt (counts FETCH
//   cycles with nothing to hand to fetch). Both are 32-bit saturating counters.

module instr_prefetch_buffer #(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F
`ifdef PREFETCH_PERF_EN
  ,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_empty_cnt
`endif
);

  localparam int unsigned   AW          = $clog2(DEPTH);
  localparam int unsigned   PW          = AW + 1;
  localparam logic [PW-1:0] DepthQ      = PW'(DEPTH);
  localparam logic [PW:0]   DepthCredit = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {RST_WAIT, FETCH, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] reqPc_q, reqPc_d;
  logic [XLEN-1:0] rspPc_q, rspPc_d;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [PW-1:0]   count_q, count_d;
  logic [PW-1:0]   outst_q, outst_d;
  logic [PW-1:0]   drop_q, drop_d;

  logic [XLEN-1:0] pcMem    [DEPTH];
  logic [XLEN-1:0] instrMem [DEPTH];

  logic [PW:0]     credit;
  logic            accept;
  logic            push;
  logic            pop;

  // Head of queue is presented straight from storage; when empty the data
  // outputs are forced to zero so they match the reset values.
  assign instr_valid   = (count_q != '0);
  assign PCF           = instr_valid ? pcMem[rdPtr_q[AW-1:0]] : '0;
  assign InstrF        = instr_valid ? instrMem[rdPtr_q[AW-1:0]] : '0;
  assign PCPlus4F      = PCF + XLEN'(4);
  assign imem_req_addr = reqPc_q;

  // Next-state logic. Buffered entries plus in-flight requests may never
  // exceed DEPTH, which guarantees every non-stale response has a free slot.
  // A redirect overrides the normal pointer/PC updates and marks everything
  // still in flight after this cycle as stale.
  always_comb begin
    state_d = state_q;
    reqPc_d = reqPc_q;
    rspPc_d = rspPc_q;
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    outst_d = outst_q;
    drop_d  = drop_q;

    credit         = {1'b0, count_q} + {1'b0, outst_q};
    imem_req_valid = (state_q == FETCH) && (credit < DepthCredit) && !PCSrcE;
    accept         = imem_req_valid && imem_req_ready;
    push           = imem_rsp_valid && !PCSrcE && (drop_q == '0);
    pop            = instr_valid && instr_ready && !PCSrcE;

    if (accept) begin
      reqPc_d = reqPc_q + XLEN'(4);
    end

    unique case ({accept, imem_rsp_valid})
      2'b10:   outst_d = outst_q + PW'(1);
      2'b01:   outst_d = outst_q - PW'(1);
      default: outst_d = outst_q;
    endcase

    if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - PW'(1);
    end

    if (push) begin
      rspPc_d = rspPc_q + XLEN'(4);
      wrPtr_d = wrPtr_q + PW'(1);
    end

    if (pop) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      RST_WAIT: state_d = FETCH;
      FETCH:    state_d = FETCH;
      FLUSH:    if (drop_d == '0) state_d = FETCH;
      default:  state_d = RST_WAIT;
    endcase

    if (PCSrcE) begin
      reqPc_d = PCTargetE;
      rspPc_d = PCTargetE;
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      drop_d  = outst_d;
      state_d = (outst_d != '0) ? FLUSH : FETCH;
    end
  end

  // Control and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_WAIT;
      reqPc_q <= RESET_PC;
      rspPc_q <= RESET_PC;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      reqPc_q <= reqPc_d;
      rspPc_q <= rspPc_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pcMem[wrPtr_q[AW-1:0]]    <= rspPc_q;
      instrMem[wrPtr_q[AW-1:0]] <= imem_rsp_data;
    end
  end

  // Overflow can only happen if the credit accounting is broken.
  assert property (@(posedge clk) disable iff (!rst) !(push && (count_q == DepthQ)));

`ifdef PREFETCH_PERF_EN
  logic [31:0] flushCnt_q, flushCnt_d;
  logic [31:0] emptyCnt_q, emptyCnt_d;

  // Saturating event counters.
  always_comb begin
    flushCnt_d = flushCnt_q;
    emptyCnt_d = emptyCnt_q;
    if (PCSrcE && (flushCnt_q != '1)) begin
      flushCnt_d = flushCnt_q + 32'd1;
    end
    if ((state_q == FETCH) && !instr_valid && (emptyCnt_q != '1)) begin
      emptyCnt_d = emptyCnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flushCnt_q <= '0;
      emptyCnt_q <= '0;
    end else begin
      flushCnt_q <= flushCnt_d;
      emptyCnt_q <= emptyCnt_d;
    end
  end

  assign perf_flush_cnt = flushCnt_q;
  assign perf_empty_cnt = emptyCnt_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer
//
// Purpose: exercises instr_prefetch_buffer (DEPTH=4, XLEN=32, RESET_PC=0)
// against an in-order instruction memory stand-in and a program-order model
// of the PCs that fetch should receive.
// Ports: none (top-level bench).
// Define PREFETCH_PERF_EN to also cover the performance counters.

module tb_instr_prefetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
`ifdef PREFETCH_PERF_EN
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_empty_cnt;
`endif

  always #5 clk = ~clk;

  instr_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .XLEN     (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .InstrF         (InstrF),
    .PCF            (PCF),
    .PCPlus4F       (PCPlus4F)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_flush_cnt (perf_flush_cnt),
    .perf_empty_cnt (perf_empty_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;

  int          checks = 0;
  int          errors = 0;
  memReq_t     memQ[$];
  logic [31:0] popLog[$];
  logic [31:0] reqExp;
  logic [31:0] expPc;
  int          cycle = 0;
  int          acceptCnt = 0;
  int          popCnt = 0;
  int          flushCnt = 0;
  bit          prevRedirect = 1'b0;
  int          readyPct = 100;
  int          rspPct = 100;
  int          maxLat = 1;
  int          popPct = 100;
  bit          rspHold = 1'b0;

  // Contents of instruction memory as a function of the word address.
  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check and update the
  // model just before the rising edge that commits them.
  task automatic applyStimulus(input bit redirect, input logic [31:0] target);
    bit      doRsp;
    bit      accept;
    bit      pop;
    memReq_t req;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < readyPct);
    doRsp = !rspHold && (memQ.size() > 0) && (memQ[0].due <= cycle) &&
            ($urandom_range(99) < rspPct);
    imem_rsp_valid = doRsp;
    imem_rsp_data  = doRsp ? memData(memQ[0].addr) : $urandom;
    PCSrcE         = redirect;
    PCTargetE      = redirect ? target : $urandom;
    instr_ready    = ($urandom_range(99) < popPct);
    #1;
    if (prevRedirect) checkOutput("validAfterRedirect", 32'(instr_valid), 32'd0);
    if (redirect) checkOutput("reqValidInRedirect", 32'(imem_req_valid), 32'd0);
    accept = imem_req_valid && imem_req_ready;
    pop    = instr_valid && instr_ready && !redirect;
    if (accept) begin
      checkOutput("reqAddr", imem_req_addr, reqExp);
      reqExp   = reqExp + 32'd4;
      req.addr = imem_req_addr;
      req.due  = cycle + int'($urandom_range(maxLat, 1));
      memQ.push_back(req);
      checkOutput("creditLimit", 32'(memQ.size() <= DEPTH), 32'd1);
      acceptCnt++;
    end
    if (pop) begin
      checkOutput("popPc", PCF, expPc);
      checkOutput("popInstr", InstrF, memData(expPc));
      checkOutput("popPcPlus4", PCPlus4F, expPc + 32'd4);
      popLog.push_back(PCF);
      expPc = expPc + 32'd4;
      popCnt++;
    end
    if (doRsp) void'(memQ.pop_front());
    if (redirect) begin
      reqExp = target;
      expPc  = target;
      flushCnt++;
    end
    prevRedirect = redirect;
    cycle++;
    @(posedge clk);
  endtask

  task automatic runSteps(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0);
  endtask

  // Run until the given number of pops is logged, bounded by a cycle budget.
  task automatic runUntilPops(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while ((popLog.size() < n) && (k < budget)) begin
      applyStimulus(1'b0, 32'h0);
      k++;
    end
    if (popLog.size() < n) checkOutput({tag, "Timeout"}, 32'(popLog.size()), 32'(n));
  endtask

  task automatic setKnobs(input int rdy, input int rsp, input int lat, input int pp);
    readyPct = rdy;
    rspPct   = rsp;
    maxLat   = lat;
    popPct   = pp;
  endtask

  // Assert reset at a falling edge, check outputs immediately, release later.
  task automatic doReset();
    @(negedge clk);
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    PCSrcE         = 1'b0;
    PCTargetE      = 32'h0;
    instr_ready    = 1'b0;
    #1;
    checkOutput("rstReqValid", 32'(imem_req_valid), 32'd0);
    checkOutput("rstInstrValid", 32'(instr_valid), 32'd0);
    checkOutput("rstPCF", PCF, 32'h0);
    checkOutput("rstInstrF", InstrF, 32'h0);
    checkOutput("rstPCPlus4F", PCPlus4F, 32'h4);
`ifdef PREFETCH_PERF_EN
    checkOutput("rstPerfFlush", perf_flush_cnt, 32'h0);
    checkOutput("rstPerfEmpty", perf_empty_cnt, 32'h0);
`endif
    memQ.delete();
    popLog.delete();
    reqExp       = 32'h0;
    expPc        = 32'h0;
    acceptCnt    = 0;
    flushCnt     = 0;
    prevRedirect = 1'b0;
    rspHold      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Stop a runaway simulation.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          p0;
    logic [31:0] t;
    rst = 1'b1;

    // Streaming: one instruction per cycle in program order from address 0.
    doReset();
    setKnobs(100, 100, 1, 100);
    runSteps(10);
    p0 = popCnt;
    runSteps(10);
    checkOutput("streamRate", 32'(popCnt - p0), 32'd10);
    for (int i = 0; i < 8; i++)
      checkOutput("streamPc", (i < popLog.size()) ? popLog[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // Fetch stalled: exactly DEPTH requests, head held at address 0.
    doReset();
    setKnobs(100, 100, 1, 0);
    runSteps(10);
    #1;
    checkOutput("stallAccepts", 32'(acceptCnt), 32'(DEPTH));
    checkOutput("stallValid", 32'(instr_valid), 32'd1);
    checkOutput("stallPCF", PCF, 32'h0);

    // Redirect with two requests still in flight.
    doReset();
    setKnobs(100, 100, 1, 100);
    rspHold = 1'b1;
    for (int k = 0; (k < 20) && (memQ.size() < 2); k++) applyStimulus(1'b0, 32'h0);
    checkOutput("twoOutstanding", 32'(memQ.size()), 32'd2);
    applyStimulus(1'b1, 32'h100);
    rspHold = 1'b0;
    popLog.delete();
    runUntilPops(2, 40, "redir2");
    if (popLog.size() >= 2) begin
      checkOutput("redirFirst", popLog[0], 32'h100);
      checkOutput("redirSecond", popLog[1], 32'h104);
    end

    // Redirect in a cycle that also carries a response.
    doReset();
    setKnobs(100, 100, 1, 100);
    runSteps(6);
    applyStimulus(1'b1, 32'h2000);
    popLog.delete();
    runUntilPops(1, 40, "redirRsp");
    if (popLog.size() >= 1) checkOutput("redirRspFirst", popLog[0], 32'h2000);

    // Redirect to the top word: PC arithmetic wraps to zero.
    applyStimulus(1'b1, 32'hFFFF_FFFC);
    popLog.delete();
    runUntilPops(2, 40, "wrap");
    if (popLog.size() >= 2) begin
      checkOutput("wrapFirst", popLog[0], 32'hFFFF_FFFC);
      checkOutput("wrapSecond", popLog[1], 32'h0);
    end

`ifdef PREFETCH_PERF_EN
    // Three redirects counted from reset.
    doReset();
    setKnobs(100, 100, 1, 100);
    runSteps(5);
    applyStimulus(1'b1, 32'h40);
    runSteps(3);
    applyStimulus(1'b1, 32'h80);
    applyStimulus(1'b1, 32'hC0);
    runSteps(2);
    checkOutput("perfFlush3", perf_flush_cnt, 32'd3);
`endif

    // Random traffic: varying memory/fetch behaviour and random redirects.
    doReset();
    for (int seg = 0; seg < 15; seg++) begin
      setKnobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 40)),
               int'($urandom_range(4, 1)), int'($urandom_range(100, 20)));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(99) < 4) begin
          t = $urandom;
          t = t & 32'hFFFF_FFFC;
          applyStimulus(1'b1, t);
        end else begin
          applyStimulus(1'b0, 32'h0);
        end
      end
    end
    checkOutput("randomMadeProgress", 32'(popCnt > 500), 32'd1);
`ifdef PREFETCH_PERF_EN
    checkOutput("perfFlushRandom", perf_flush_cnt, 32'(flushCnt));
`endif

    // Reset while traffic is in progress, then resume cleanly.
    setKnobs(100, 100, 1, 100);
    runSteps(7);
    doReset();
    runUntilPops(4, 20, "afterReset");
    if (popLog.size() >= 4) checkOutput("afterResetPc", popLog[3], 32'hC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
